// File: rtl/duck_pkg.sv
// Shared sizing constants and types for the duck sprite fetch path.
package duck_pkg;
    localparam int SPRITE_W   = 32;
    localparam int SPRITE_H   = 32;
    localparam int FRAMES     = 3;
    localparam int FRAME_DIV  = 8;
    localparam int NUM_COLORS = 6;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] pal_idx_t;

    localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
endpackage

// File: rtl/duck_anim_ctr.sv
// vsync rise detector driving the shadow-register load strobe and the
// divided animation frame counter.
module duck_anim_ctr
    import duck_pkg::*;
#(
    parameter int FRAMES    = 3,
    parameter int FRAME_DIV = 8,
    parameter int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    parameter int DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               vsync,
    output logic [FRAME_W-1:0] frame,
    output logic               latch
);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

    logic             vsync_q;
    logic [DIV_W-1:0] div;

    assign latch = vsync & ~vsync_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vsync_q <= 1'b0;
            div     <= '0;
            frame   <= '0;
        end else begin
            vsync_q <= vsync;
            if (latch) begin
                if (div == DIV_LAST) begin
                    div   <= '0;
                    frame <= (frame == FRAME_LAST) ? '0 : frame + FRAME_W'(1);
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/duck_sprite_fetch.sv
// Two-stage sprite fetch: hit test + ROM addressing, then opacity filter
// producing the palette index. Duck state only changes on vsync rise.
module duck_sprite_fetch
    import duck_pkg::*;
#(
    parameter int SPRITE_W   = duck_pkg::SPRITE_W,
    parameter int SPRITE_H   = duck_pkg::SPRITE_H,
    parameter int FRAMES     = duck_pkg::FRAMES,
    parameter int FRAME_DIV  = duck_pkg::FRAME_DIV,
    parameter int NUM_COLORS = duck_pkg::NUM_COLORS,
    parameter int ADDR_W     = $clog2(SPRITE_W * SPRITE_H * FRAMES)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync,
    input  logic              pix_en,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  coord_t            duck_x,
    input  coord_t            duck_y,
    input  logic              duck_dir,
    input  logic              duck_active,
    output logic [ADDR_W-1:0] rom_addr,
    input  pal_idx_t          rom_data,
    output pal_idx_t          index,
    output logic              in_sprite
);
    localparam int COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [FRAME_W-1:0] frame;
    logic               latch;

    duck_anim_ctr #(
        .FRAMES   (FRAMES),
        .FRAME_DIV(FRAME_DIV),
        .FRAME_W  (FRAME_W)
    ) u_anim (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .vsync  (vsync),
        .frame  (frame),
        .latch  (latch)
    );

    coord_t sh_x, sh_y;
    logic   sh_dir, sh_active;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_dir    <= 1'b0;
            sh_active <= 1'b0;
        end else if (latch) begin
            sh_x      <= duck_x;
            sh_y      <= duck_y;
            sh_dir    <= duck_dir;
            sh_active <= duck_active;
        end
    end

    // 11-bit compares keep a right-edge sprite from wrapping onto column 0.
    logic [10:0]       x_ext, y_ext, sx_ext, sy_ext;
    logic              hit;
    logic [COL_W-1:0]  col_raw, col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        x_ext   = {1'b0, DrawX};
        y_ext   = {1'b0, DrawY};
        sx_ext  = {1'b0, sh_x};
        sy_ext  = {1'b0, sh_y};
        hit     = sh_active & pix_en
                & (x_ext >= sx_ext) & (x_ext < sx_ext + 11'(SPRITE_W))
                & (y_ext >= sy_ext) & (y_ext < sy_ext + 11'(SPRITE_H));
        col_raw = COL_W'(DrawX - sh_x);
        col     = sh_dir ? (COL_W'(SPRITE_W - 1) - col_raw) : col_raw;
        row     = ROW_W'(DrawY - sh_y);
        addr_next = ADDR_W'(frame) * ADDR_W'(SPRITE_W * SPRITE_H)
                  + ADDR_W'(row) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(col);
    end

    logic hit_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit_q    <= 1'b0;
        end else begin
            hit_q <= hit;
            if (hit) rom_addr <= addr_next;
        end
    end

    logic opaque;
    assign opaque = hit_q && (rom_data != TRANSPARENT_IDX)
                 && ({1'b0, rom_data} < 5'(NUM_COLORS));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            index     <= TRANSPARENT_IDX;
            in_sprite <= 1'b0;
        end else begin
            index     <= opaque ? rom_data : TRANSPARENT_IDX;
            in_sprite <= opaque;
        end
    end
endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch with hand-computed expectations.
module tb_duck_sprite_fetch;
    logic        Clk = 1'b0, Reset_n = 1'b0, vsync = 1'b0, pix_en = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, duck_x = '0, duck_y = '0;
    logic        duck_dir = 1'b0, duck_active = 1'b0;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data = '0, index;
    logic        in_sprite;

    int checks = 0, fails = 0, rises = 0;

    logic [11:0] a;
    logic        s;
    logic [3:0]  i;

    always #5 Clk = ~Clk;

    duck_sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .pix_en(pix_en),
        .DrawX(DrawX), .DrawY(DrawY), .duck_x(duck_x), .duck_y(duck_y),
        .duck_dir(duck_dir), .duck_active(duck_active),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .index(index), .in_sprite(in_sprite)
    );

    task automatic pulse_vsync(input int hold);
        @(negedge Clk) vsync = 1'b1;
        repeat (hold) @(negedge Clk);
        vsync = 1'b0;
        rises++;
    endtask

    // One pixel, then idle; returns rom_addr at n+1 and index/in_sprite at n+2.
    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d,
                         output logic [11:0] ao, output logic so, output logic [3:0] io);
        @(negedge Clk);
        DrawX = x; DrawY = y; pix_en = 1'b1; rom_data = d;
        @(negedge Clk);
        pix_en = 1'b0;
        ao = rom_addr;
        @(negedge Clk);
        so = in_sprite;
        io = index;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rom_addr !== 12'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        checks++; if (index !== 4'd0 || in_sprite !== 1'b0) begin fails++; $display("FAIL reset_out: got idx=%0d in=%0b expected 0/0", index, in_sprite); end
        duck_x = 10'd100; duck_y = 10'd50; duck_active = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        pixel(10'd100, 10'd50, 4'd2, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL reset_inactive: got in=%0b idx=%0d expected 0/0", s, i); end
    endtask

    task automatic test_basic();
        pulse_vsync(1);
        pixel(10'd100, 10'd50, 4'd2, a, s, i);
        checks++; if (a !== 12'd0) begin fails++; $display("FAIL basic_addr: got %0d expected 0", a); end
        checks++; if (s !== 1'b1 || i !== 4'd2) begin fails++; $display("FAIL basic_out: got in=%0b idx=%0d expected 1/2", s, i); end
        pixel(10'd101, 10'd51, 4'd3, a, s, i);
        checks++; if (a !== 12'd33 || s !== 1'b1 || i !== 4'd3) begin fails++; $display("FAIL basic_101_51: got addr=%0d in=%0b idx=%0d expected 33/1/3", a, s, i); end
    endtask

    task automatic test_bounds();
        pixel(10'd99, 10'd50, 4'd2, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL bound_x99: got in=%0b idx=%0d expected 0/0", s, i); end
        pixel(10'd132, 10'd50, 4'd2, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL bound_x132: got in=%0b idx=%0d expected 0/0", s, i); end
        pixel(10'd100, 10'd49, 4'd2, a, s, i);
        checks++; if (s !== 1'b0) begin fails++; $display("FAIL bound_y49: got in=%0b expected 0", s); end
        pixel(10'd100, 10'd82, 4'd2, a, s, i);
        checks++; if (s !== 1'b0) begin fails++; $display("FAIL bound_y82: got in=%0b expected 0", s); end
        pixel(10'd131, 10'd81, 4'd2, a, s, i);
        checks++; if (a !== 12'd1023 || s !== 1'b1 || i !== 4'd2) begin fails++; $display("FAIL bound_corner: got addr=%0d in=%0b idx=%0d expected 1023/1/2", a, s, i); end
        @(negedge Clk);
        DrawX = 10'd110; DrawY = 10'd60; pix_en = 1'b0; rom_data = 4'd2;
        repeat (2) @(negedge Clk);
        checks++; if (in_sprite !== 1'b0 || rom_addr !== 12'd1023) begin fails++; $display("FAIL bound_blank: got in=%0b addr=%0d expected 0/1023", in_sprite, rom_addr); end
    endtask

    task automatic test_mirror();
        duck_dir = 1'b1;
        pulse_vsync(1);
        pixel(10'd100, 10'd50, 4'd1, a, s, i);
        checks++; if (a !== 12'd31 || s !== 1'b1) begin fails++; $display("FAIL mirror_left: got addr=%0d in=%0b expected 31/1", a, s); end
        pixel(10'd131, 10'd51, 4'd1, a, s, i);
        checks++; if (a !== 12'd32) begin fails++; $display("FAIL mirror_right: got addr=%0d expected 32", a); end
        duck_dir = 1'b0;
        pulse_vsync(1);
    endtask

    task automatic test_frame();
        while (rises % 8 != 7) pulse_vsync(1);
        pulse_vsync(20);
        pixel(10'd100, 10'd50, 4'd1, a, s, i);
        checks++; if (a !== 12'd1024) begin fails++; $display("FAIL frame1_addr: got %0d expected 1024", a); end
        pixel(10'd131, 10'd81, 4'd1, a, s, i);
        checks++; if (a !== 12'd2047) begin fails++; $display("FAIL frame1_corner: got %0d expected 2047", a); end
        while (rises < 16) pulse_vsync(1);
        pixel(10'd100, 10'd50, 4'd1, a, s, i);
        checks++; if (a !== 12'd2048) begin fails++; $display("FAIL frame2_addr: got %0d expected 2048", a); end
        while (rises < 24) pulse_vsync(1);
        pixel(10'd100, 10'd50, 4'd1, a, s, i);
        checks++; if (a !== 12'd0 || s !== 1'b1) begin fails++; $display("FAIL frame_wrap: got addr=%0d in=%0b expected 0/1", a, s); end
    endtask

    task automatic test_colors();
        pixel(10'd100, 10'd50, 4'd0, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL color0: got in=%0b idx=%0d expected 0/0", s, i); end
        pixel(10'd100, 10'd50, 4'd7, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL color7: got in=%0b idx=%0d expected 0/0", s, i); end
        pixel(10'd100, 10'd50, 4'd5, a, s, i);
        checks++; if (s !== 1'b1 || i !== 4'd5) begin fails++; $display("FAIL color5: got in=%0b idx=%0d expected 1/5", s, i); end
        pixel(10'd100, 10'd50, 4'd6, a, s, i);
        checks++; if (s !== 1'b0 || i !== 4'd0) begin fails++; $display("FAIL color6: got in=%0b idx=%0d expected 0/0", s, i); end
        duck_x = 10'd1000;
        pulse_vsync(1);
        pixel(10'd5, 10'd50, 4'd3, a, s, i);
        checks++; if (s !== 1'b0 || a !== 12'd0) begin fails++; $display("FAIL edge_nowrap: got in=%0b addr=%0d expected 0/0", s, a); end
        pixel(10'd1023, 10'd50, 4'd3, a, s, i);
        checks++; if (s !== 1'b1 || a !== 12'd23) begin fails++; $display("FAIL edge_1023: got in=%0b addr=%0d expected 1/23", s, a); end
        pixel(10'd5, 10'd50, 4'd3, a, s, i);
        checks++; if (s !== 1'b0 || a !== 12'd23) begin fails++; $display("FAIL addr_hold: got in=%0b addr=%0d expected 0/23", s, a); end
    endtask

    task automatic test_midframe();
        duck_x = 10'd100;
        pulse_vsync(1);
        duck_x = 10'd200;
        pixel(10'd100, 10'd50, 4'd4, a, s, i);
        checks++; if (s !== 1'b1 || i !== 4'd4 || a !== 12'd0) begin fails++; $display("FAIL mid_old: got in=%0b idx=%0d addr=%0d expected 1/4/0", s, i, a); end
        pixel(10'd200, 10'd50, 4'd4, a, s, i);
        checks++; if (s !== 1'b0) begin fails++; $display("FAIL mid_new_early: got in=%0b expected 0", s); end
        pulse_vsync(1);
        pixel(10'd200, 10'd50, 4'd4, a, s, i);
        checks++; if (s !== 1'b1 || a !== 12'd0) begin fails++; $display("FAIL mid_new_late: got in=%0b addr=%0d expected 1/0", s, a); end
    endtask

    task automatic test_simultaneous();
        while (rises % 8 != 7) pulse_vsync(1);
        @(negedge Clk);
        DrawX = 10'd201; DrawY = 10'd50; pix_en = 1'b1; rom_data = 4'd3;
        vsync = 1'b1; duck_x = 10'd300;
        @(negedge Clk);
        pix_en = 1'b0; vsync = 1'b0; rises++;
        a = rom_addr;
        @(negedge Clk);
        checks++; if (a !== 12'd1 || in_sprite !== 1'b1 || index !== 4'd3) begin fails++; $display("FAIL simul_old: got addr=%0d in=%0b idx=%0d expected 1/1/3", a, in_sprite, index); end
        pixel(10'd300, 10'd50, 4'd4, a, s, i);
        checks++; if (a !== 12'd1024 || s !== 1'b1) begin fails++; $display("FAIL simul_new: got addr=%0d in=%0b expected 1024/1", a, s); end
        pixel(10'd201, 10'd50, 4'd4, a, s, i);
        checks++; if (s !== 1'b0) begin fails++; $display("FAIL simul_oldpos: got in=%0b expected 0", s); end
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        DrawX = 10'd301; DrawY = 10'd50; pix_en = 1'b1; rom_data = 4'd4;
        repeat (3) @(negedge Clk);
        checks++; if (in_sprite !== 1'b1 || index !== 4'd4 || rom_addr !== 12'd1025) begin fails++; $display("FAIL pre_reset: got in=%0b idx=%0d addr=%0d expected 1/4/1025", in_sprite, index, rom_addr); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (in_sprite !== 1'b0 || index !== 4'd0 || rom_addr !== 12'd0) begin fails++; $display("FAIL reset_mid: got in=%0b idx=%0d addr=%0d expected 0/0/0", in_sprite, index, rom_addr); end
        @(negedge Clk);
        Reset_n = 1'b1; rises = 0;
        repeat (3) @(negedge Clk);
        checks++; if (in_sprite !== 1'b0) begin fails++; $display("FAIL reset_release: got in=%0b expected 0", in_sprite); end
        pix_en = 1'b0;
        duck_x = 10'd100;
        pulse_vsync(1);
        pixel(10'd101, 10'd50, 4'd4, a, s, i);
        checks++; if (a !== 12'd1 || s !== 1'b1) begin fails++; $display("FAIL reset_frame0: got addr=%0d in=%0b expected 1/1", a, s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_mirror();
        test_frame();
        test_colors();
        test_midframe();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
